// File: rtl/dmac_pkg.sv
// Shared types and AHB-Lite constants for the DMA write engine.
// State encoding plus the transfer-type and size codes it drives.
package dmac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]  HSIZE_WORD    = 3'b010;
    localparam logic [31:0] ADDR_STEP     = 32'd4;

endpackage

// File: rtl/dmac_wr_engine.sv
// DMA write engine: pops words from a show-ahead FIFO and issues single AHB-Lite word writes.
// Latency: first NONSEQ 2 cycles after start, then one word per 2 cycles while the FIFO has data.
// Backpressure: waits in WAIT while the FIFO is empty; HREADY=0 stretches the address or data phase.
module dmac_wr_engine
    import dmac_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [31:0]   dst_addr,
    input  logic [15:0]   xfer_cnt,
    input  logic          dst_incr,
    output logic          busy,
    output logic          done,
    output logic          error,
    output logic          fifo_rd,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_empty,
    output logic [31:0]   HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [DW-1:0] HWDATA,
    input  logic          HREADY,
    input  logic          HRESP
);

    if (DW != 32 || AW < 1) begin : g_param_check
        $error("dmac_wr_engine: DW must be 32 and AW at least 1");
    end

    state_t        state;
    state_t        nxt;
    logic [15:0]   remaining;
    logic [31:0]   addr;
    logic          incr;
    logic [DW-1:0] data;

    assign HADDR  = addr;
    assign HWDATA = data;
    assign HSIZE  = HSIZE_WORD;

    // The pop coincides with the accepted address phase, so the head word is
    // captured and removed on the same edge.
    assign fifo_rd = (state == ST_ADDR) && HREADY && !fifo_empty && !rst;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    nxt = (xfer_cnt == 16'd0) ? ST_FIN : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (abort) begin
                    nxt = ST_FIN;
                end else if (!fifo_empty) begin
                    nxt = ST_ADDR;
                end
            end
            // Abort is ignored here: an issued address phase cannot be retracted.
            ST_ADDR: begin
                if (HREADY) begin
                    nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (HRESP) begin
                    if (HREADY) begin
                        nxt = ST_FIN;
                    end
                end else if (HREADY) begin
                    if (remaining == 16'd1 || abort) begin
                        nxt = ST_FIN;
                    end else if (!fifo_empty) begin
                        nxt = ST_ADDR;
                    end else begin
                        nxt = ST_WAIT;
                    end
                end
            end
            ST_FIN:  nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= 16'd0;
            addr      <= 32'd0;
            incr      <= 1'b0;
            data      <= '0;
            error     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            HTRANS    <= HTRANS_IDLE;
            HWRITE    <= 1'b0;
        end else begin
            state  <= nxt;
            busy   <= (nxt != ST_IDLE);
            done   <= (nxt == ST_FIN);
            HTRANS <= (nxt == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            HWRITE <= (nxt == ST_ADDR);

            if (state == ST_IDLE && start) begin
                addr      <= dst_addr;
                remaining <= xfer_cnt;
                incr      <= dst_incr;
                error     <= 1'b0;
            end

            if (fifo_rd) begin
                data <= fifo_rdata;
            end

            if (state == ST_DATA && HRESP) begin
                error <= 1'b1;
            end

            if (state == ST_DATA && HREADY && !HRESP) begin
                remaining <= remaining - 16'd1;
                if (incr) begin
                    addr <= addr + ADDR_STEP;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmac_wr_engine.sv
// Directed bench for dmac_wr_engine: FIFO model, AHB write monitor and per-scenario tasks.
module tb_dmac_wr_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [31:0] dst_addr;
    logic [15:0] xfer_cnt;
    logic        dst_incr;
    logic        busy;
    logic        done;
    logic        error;
    logic        fifo_rd;
    logic [31:0] fifo_rdata;
    logic        fifo_empty;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HRESP;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int st_cyc = 0;

    // upstream FIFO model (show-ahead)
    logic [31:0] mem [0:255];
    logic [7:0]  wr_idx = 8'd0;
    logic [7:0]  rd_idx = 8'd0;
    assign fifo_empty = (wr_idx == rd_idx);
    assign fifo_rdata = mem[rd_idx];

    // bus monitor
    logic [31:0] wa [0:63];
    logic [31:0] wd [0:63];
    int          nw = 0;
    int          nns = 0;
    int          nrd_empty = 0;
    logic        dph = 1'b0;
    logic [31:0] dph_a = 32'd0;

    dmac_wr_engine #(.DW(32), .AW(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .dst_addr   (dst_addr),
        .xfer_cnt   (xfer_cnt),
        .dst_incr   (dst_incr),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .fifo_rd    (fifo_rd),
        .fifo_rdata (fifo_rdata),
        .fifo_empty (fifo_empty),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HSIZE      (HSIZE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HRESP      (HRESP)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd && !fifo_empty) rd_idx <= rd_idx + 8'd1;
    end

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            dph = 1'b0;
        end else begin
            if (dph && HREADY) begin
                if (!HRESP) begin
                    wa[nw] = dph_a;
                    wd[nw] = HWDATA;
                    nw++;
                end
                dph = 1'b0;
            end
            if (HTRANS == 2'b10) begin
                nns++;
                if (HREADY) begin
                    dph   = 1'b1;
                    dph_a = HADDR;
                end
            end
            if (fifo_rd && fifo_empty) nrd_empty++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_idx] = w;
        wr_idx = wr_idx + 8'd1;
    endtask

    task automatic flush();
        wr_idx = rd_idx;
    endtask

    task automatic do_start(input logic [31:0] a, input logic [15:0] c, input logic i);
        dst_addr = a;
        xfer_cnt = c;
        dst_incr = i;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        st_cyc   = cyc;
    endtask

    task automatic wait_done(input int budget, output int lat);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        lat = (done === 1'b1) ? (cyc - st_cyc) : -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/done/error/fifo_rd=%b%b%b%b want 0000", busy, done, error, fifo_rd);
        end
        checks++;
        if (HTRANS !== 2'b00 || HADDR !== 32'd0 || HWDATA !== 32'd0 || HWRITE !== 1'b0 || HSIZE !== 3'b010) begin
            errors++;
            $display("FAIL reset_bus: HTRANS=%b HADDR=%h HWDATA=%h HWRITE=%b HSIZE=%b want 00/0/0/0/010",
                     HTRANS, HADDR, HWDATA, HWRITE, HSIZE);
        end
        rst = 1'b0;
        step(1);
        checks++;
        if (busy !== 1'b0 || HTRANS !== 2'b00) begin
            errors++;
            $display("FAIL reset_release: busy=%b HTRANS=%b want 0/00", busy, HTRANS);
        end
    endtask

    task automatic test_basic();
        logic [31:0] ea [0:3] = '{32'h2000_0000, 32'h2000_0004, 32'h2000_0008, 32'h2000_000C};
        logic [31:0] ed [0:3] = '{32'hAAAA_BBBB, 32'hCCCC_DDDD, 32'hEEEE_FFFF, 32'h1111_2222};
        int base = nw;
        logic [7:0] p0 = rd_idx;
        int lat;
        for (int i = 0; i < 4; i++) push(ed[i]);
        do_start(32'h2000_0000, 16'd4, 1'b1);
        checks++;
        if (HTRANS !== 2'b00 || busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_wait: HTRANS=%b busy=%b want 00/1", HTRANS, busy);
        end
        step(1);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h2000_0000 || HWRITE !== 1'b1 || HSIZE !== 3'b010 || fifo_rd !== 1'b1) begin
            errors++;
            $display("FAIL basic_first_addr: HTRANS=%b HADDR=%h HWRITE=%b HSIZE=%b fifo_rd=%b want 10/20000000/1/010/1",
                     HTRANS, HADDR, HWRITE, HSIZE, fifo_rd);
        end
        wait_done(40, lat);
        checks++;
        if (lat != 9) begin
            errors++;
            $display("FAIL basic_done_cycle: got %0d want 9", lat);
        end
        checks++;
        if (nw - base != 4) begin
            errors++;
            $display("FAIL basic_nwrites: got %0d want 4", nw - base);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (wa[base+i] !== ea[i] || wd[base+i] !== ed[i]) begin
                errors++;
                $display("FAIL basic_write%0d: got %h<=%h want %h<=%h", i, wa[base+i], wd[base+i], ea[i], ed[i]);
            end
        end
        step(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || rd_idx - p0 != 8'd4) begin
            errors++;
            $display("FAIL basic_after: busy=%b done=%b pops=%0d want 0/0/4", busy, done, rd_idx - p0);
        end
    endtask

    task automatic test_fifo_wait();
        int base = nw;
        int ns0 = nns;
        int bad = 0;
        int lat;
        do_start(32'h3000_0010, 16'd3, 1'b0);
        repeat (5) begin
            if (HTRANS !== 2'b00 || fifo_rd !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0 || nns != ns0) begin
            errors++;
            $display("FAIL wait_idle: bad cycles=%0d nonseq=%0d want 0/0", bad, nns - ns0);
        end
        push(32'h0101_0101);
        push(32'h0202_0202);
        push(32'h0303_0303);
        wait_done(40, lat);
        checks++;
        if (lat != 12) begin
            errors++;
            $display("FAIL wait_done_cycle: got %0d want 12", lat);
        end
        checks++;
        if (nw - base != 3 || wa[base] !== 32'h3000_0010 || wa[base+1] !== 32'h3000_0010 || wa[base+2] !== 32'h3000_0010) begin
            errors++;
            $display("FAIL wait_fixed_addr: n=%0d addrs=%h %h %h want 3 x 30000010",
                     nw - base, wa[base], wa[base+1], wa[base+2]);
        end
        checks++;
        if (wd[base] !== 32'h0101_0101 || wd[base+1] !== 32'h0202_0202 || wd[base+2] !== 32'h0303_0303) begin
            errors++;
            $display("FAIL wait_data: got %h %h %h want 01010101 02020202 03030303", wd[base], wd[base+1], wd[base+2]);
        end
        checks++;
        if (nrd_empty != 0) begin
            errors++;
            $display("FAIL rd_while_empty: got %0d want 0", nrd_empty);
        end
        step(1);
    endtask

    task automatic test_wait_states();
        int base = nw;
        logic [7:0] p0 = rd_idx;
        int bad = 0;
        int lat;
        push(32'hA0A0_0001);
        push(32'hA0A0_0002);
        push(32'hA0A0_0003);
        do_start(32'h4000_0000, 16'd3, 1'b1);
        step(4);
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (HWDATA !== 32'hA0A0_0002 || HTRANS !== 2'b00 || fifo_rd !== 1'b0) bad++;
            step(1);
        end
        HREADY = 1'b1;
        if (HWDATA !== 32'hA0A0_0002) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_hold: unstable cycles=%0d want 0 (HWDATA=%h)", bad, HWDATA);
        end
        wait_done(40, lat);
        checks++;
        if (lat != 10) begin
            errors++;
            $display("FAIL stall_done_cycle: got %0d want 10", lat);
        end
        checks++;
        if (nw - base != 3 || wa[base+2] !== 32'h4000_0008 || wd[base+1] !== 32'hA0A0_0002 || rd_idx - p0 != 8'd3) begin
            errors++;
            $display("FAIL stall_writes: n=%0d a2=%h d1=%h pops=%0d want 3/40000008/a0a00002/3",
                     nw - base, wa[base+2], wd[base+1], rd_idx - p0);
        end
        step(1);
    endtask

    task automatic test_bus_error();
        int base = nw;
        logic [7:0] p0 = rd_idx;
        int lat;
        for (int i = 1; i <= 5; i++) push(32'hE000_0000 + 32'(i));
        do_start(32'h5000_0000, 16'd5, 1'b1);
        step(4);
        HRESP  = 1'b1;
        HREADY = 1'b0;
        step(1);
        checks++;
        if (error !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL err_first: error=%b done=%b want 1/0", error, done);
        end
        HREADY = 1'b1;
        step(1);
        HRESP = 1'b0;
        checks++;
        if (done !== 1'b1 || error !== 1'b1) begin
            errors++;
            $display("FAIL err_done: done=%b error=%b want 1/1", done, error);
        end
        checks++;
        if (nw - base != 1 || wa[base] !== 32'h5000_0000 || wd[base] !== 32'hE000_0001 || rd_idx - p0 != 8'd2) begin
            errors++;
            $display("FAIL err_traffic: n=%0d a=%h d=%h pops=%0d want 1/50000000/e0000001/2",
                     nw - base, wa[base], wd[base], rd_idx - p0);
        end
        step(2);
        checks++;
        if (error !== 1'b1 || busy !== 1'b0 || rd_idx - p0 != 8'd2) begin
            errors++;
            $display("FAIL err_sticky: error=%b busy=%b pops=%0d want 1/0/2", error, busy, rd_idx - p0);
        end
        base = nw;
        do_start(32'h6000_0000, 16'd3, 1'b1);
        checks++;
        if (error !== 1'b0) begin
            errors++;
            $display("FAIL err_clear: got %b want 0", error);
        end
        wait_done(40, lat);
        checks++;
        if (lat != 7 || nw - base != 3 || wa[base+2] !== 32'h6000_0008 || wd[base] !== 32'hE000_0003 || wd[base+2] !== 32'hE000_0005) begin
            errors++;
            $display("FAIL err_restart: lat=%0d n=%0d a2=%h d0=%h d2=%h want 7/3/60000008/e0000003/e0000005",
                     lat, nw - base, wa[base+2], wd[base], wd[base+2]);
        end
        step(1);
    endtask

    task automatic test_zero_and_busy();
        int base = nw;
        int ns0 = nns;
        int lat;
        do_start(32'h7000_0000, 16'd0, 1'b1);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL zero_done: done=%b busy=%b want 1/1", done, busy);
        end
        step(1);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || nns != ns0) begin
            errors++;
            $display("FAIL zero_quiet: done=%b busy=%b nonseq=%0d want 0/0/0", done, busy, nns - ns0);
        end
        push(32'h7777_0001);
        push(32'h7777_0002);
        do_start(32'h7000_0000, 16'd2, 1'b1);
        step(1);
        dst_addr = 32'h7100_0000;
        xfer_cnt = 16'd5;
        start    = 1'b1;
        step(1);
        start    = 1'b0;
        wait_done(40, lat);
        checks++;
        if (lat != 5 || nw - base != 2 || wa[base] !== 32'h7000_0000 || wa[base+1] !== 32'h7000_0004) begin
            errors++;
            $display("FAIL busy_ignore: lat=%0d n=%0d a0=%h a1=%h want 5/2/70000000/70000004",
                     lat, nw - base, wa[base], wa[base+1]);
        end
        step(3);
        checks++;
        if (busy !== 1'b0 || nw - base != 2) begin
            errors++;
            $display("FAIL busy_no_restart: busy=%b n=%0d want 0/2", busy, nw - base);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] p0;
        int bad = 0;
        push(32'h8888_0001);
        push(32'h8888_0002);
        do_start(32'h8000_0000, 16'd2, 1'b1);
        step(1);
        rst = 1'b1;
        p0  = rd_idx;
        step(1);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0 || fifo_rd !== 1'b0 || HTRANS !== 2'b00 ||
            HADDR !== 32'd0 || HWDATA !== 32'd0 || HWRITE !== 1'b0 || HSIZE !== 3'b010) begin
            errors++;
            $display("FAIL rst_mid: busy=%b done=%b err=%b rd=%b HTRANS=%b HADDR=%h HWDATA=%h HWRITE=%b HSIZE=%b want all reset",
                     busy, done, error, fifo_rd, HTRANS, HADDR, HWDATA, HWRITE, HSIZE);
        end
        repeat (2) begin
            if (done !== 1'b0) bad++;
            step(1);
        end
        rst = 1'b0;
        repeat (2) begin
            if (done !== 1'b0 || busy !== 1'b0) bad++;
            step(1);
        end
        checks++;
        if (bad != 0 || rd_idx != p0) begin
            errors++;
            $display("FAIL rst_no_done: bad=%0d pops=%0d want 0/0", bad, rd_idx - p0);
        end
        flush();
    endtask

    task automatic test_abort();
        int base = nw;
        logic [7:0] p0 = rd_idx;
        int lat;
        push(32'h9999_0001);
        push(32'h9999_0002);
        push(32'h9999_0003);
        do_start(32'h9000_0000, 16'd3, 1'b1);
        step(1);
        HREADY = 1'b0;
        abort  = 1'b1;
        step(1);
        checks++;
        if (HTRANS !== 2'b10 || HADDR !== 32'h9000_0000 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL abort_hold_addr: HTRANS=%b HADDR=%h rd=%b want 10/90000000/0", HTRANS, HADDR, fifo_rd);
        end
        HREADY = 1'b1;
        wait_done(40, lat);
        abort = 1'b0;
        checks++;
        if (lat != 4 || nw - base != 1 || wd[base] !== 32'h9999_0001 || rd_idx - p0 != 8'd1) begin
            errors++;
            $display("FAIL abort_addr: lat=%0d n=%0d d=%h pops=%0d want 4/1/99990001/1",
                     lat, nw - base, wd[base], rd_idx - p0);
        end
        step(1);
        flush();
        base = nw;
        do_start(32'hA000_0000, 16'd2, 1'b1);
        abort = 1'b1;
        wait_done(40, lat);
        abort = 1'b0;
        checks++;
        if (lat != 1 || nw - base != 0) begin
            errors++;
            $display("FAIL abort_wait: lat=%0d n=%0d want 1/0", lat, nw - base);
        end
        step(1);
    endtask

    task automatic test_wrap();
        int base = nw;
        int lat;
        push(32'hCAFE_0001);
        push(32'hCAFE_0002);
        do_start(32'hFFFF_FFFC, 16'd2, 1'b1);
        wait_done(40, lat);
        checks++;
        if (lat != 5 || nw - base != 2 || wa[base] !== 32'hFFFF_FFFC || wa[base+1] !== 32'h0000_0000 ||
            wd[base+1] !== 32'hCAFE_0002) begin
            errors++;
            $display("FAIL addr_wrap: lat=%0d n=%0d a0=%h a1=%h d1=%h want 5/2/fffffffc/00000000/cafe0002",
                     lat, nw - base, wa[base], wa[base+1], wd[base+1]);
        end
        step(1);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        dst_addr = 32'd0;
        xfer_cnt = 16'd0;
        dst_incr = 1'b0;
        HREADY   = 1'b1;
        HRESP    = 1'b0;
        test_reset();
        test_basic();
        test_fifo_wait();
        test_wait_states();
        test_bus_error();
        test_zero_and_busy();
        test_reset_mid();
        test_abort();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
